// File: rtl/core_clock_ctrl_if.sv
// Control and status bundle for the core clock controller.
//
// Command semantics: run_i, stop_i, step_i and core_rst_req_i are single-cycle
// pulses sampled on the rising edge of clk. There is no ready/acknowledge; the
// controller always accepts a pulse in the cycle it is seen. When several pulses
// coincide, core_rst_req_i wins over stop_i, stop_i over run_i, run_i over step_i.
// step_count_i and div_i are plain levels sampled when they are used.
interface core_clock_ctrl_if #(
  parameter int DIV_WIDTH = 16,
  parameter int STEP_BITS = 32
);
  // Controller -> clock block
  logic [DIV_WIDTH-1:0] div_i;
  logic                 run_i;
  logic                 stop_i;
  logic                 step_i;
  logic [STEP_BITS-1:0] step_count_i;
  logic                 core_rst_req_i;

  // Clock block -> controller / core
  logic                 clk_core_o;
  logic                 rst_core_o;
  logic                 core_tick_o;
  logic                 running_o;
  logic [STEP_BITS-1:0] steps_left_o;
  logic [1:0]           state_dbg;

  modport master (
    output div_i, run_i, stop_i, step_i, step_count_i, core_rst_req_i,
    input  clk_core_o, rst_core_o, core_tick_o, running_o, steps_left_o, state_dbg
  );

  modport slave (
    input  div_i, run_i, stop_i, step_i, step_count_i, core_rst_req_i,
    output clk_core_o, rst_core_o, core_tick_o, running_o, steps_left_o, state_dbg
  );
endinterface

// File: rtl/core_clock_ctrl.sv
// Core clock generator: programmable divider producing a registered core
// clock, a core reset sequenced over a fixed number of core rising edges, and
// run / stop / N-edge step control so the processor under test can be frozen
// and stepped. Stopping only ever gates the low phase, so the core clock never
// produces a short phase.
module core_clock_ctrl #(
  parameter int DIV_WIDTH        = 16,
  parameter int STEP_BITS        = 32,
  parameter int RESET_CLK_CYCLES = 20,
  parameter int START_RUNNING    = 1
) (
  input logic             clk,
  input logic             rst,
  core_clock_ctrl_if.slave ctl
);

  // Edge counter must be at least one bit wide even for a zero-length hold.
  localparam int EDGE_W = (RESET_CLK_CYCLES < 1) ? 1 : $clog2(RESET_CLK_CYCLES + 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(RESET_CLK_CYCLES);

  // HOLD: core in reset, clock free-running.
  // RUN : clock free-running.
  // STOP: clock parked low.
  // STEP: clock runs until steps_q rising edges have been issued.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [STEP_BITS-1:0] steps_q, steps_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic                 rst_core_q;

  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 div_valid_q;
  logic                 clk_core_q, clk_core_d;
  logic                 tick_q;

  // ---------------------------------------------------------------------------
  // Divider decode
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 at_end;
  logic                 permit_rise;
  logic                 do_rise;
  logic                 do_fall;

  // Until the first post-reset cycle has captured div_i, use div_i directly so
  // the very first phase already has the requested length.
  assign div_eff = div_valid_q ? div_q : ctl.div_i;
  assign at_end  = (phase_q == div_eff);

  // Rising edges are gated by state; falling edges never are, so a high phase
  // always runs to completion.
  assign permit_rise = (state_q == ST_HOLD) ||
                       (state_q == ST_RUN)  ||
                       ((state_q == ST_STEP) && (steps_q != '0));

  assign do_fall = clk_core_q && at_end;
  assign do_rise = !clk_core_q && permit_rise && at_end;

  // Next phase count and core clock level.
  always_comb begin
    phase_d    = phase_q + DIV_WIDTH'(1);
    clk_core_d = clk_core_q;
    if (do_fall) begin
      phase_d    = '0;
      clk_core_d = 1'b0;
    end else if (do_rise) begin
      phase_d    = '0;
      clk_core_d = 1'b1;
    end else if (!clk_core_q && !permit_rise) begin
      // Parked low: restart the low phase from zero when released, so the
      // first phase after a stop is full length.
      phase_d = '0;
    end
  end

  // Divider registers: phase counter, core clock, tick, and divisor capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      div_q       <= '0;
      div_valid_q <= 1'b0;
      clk_core_q  <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      clk_core_q <= clk_core_d;
      tick_q     <= do_rise;
      // The divisor only changes at the start of a low phase, so a new value
      // can never shorten a phase already under way.
      if (!div_valid_q) begin
        div_q       <= ctl.div_i;
        div_valid_q <= 1'b1;
      end else if (do_fall) begin
        div_q <= ctl.div_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // Next state, remaining steps and reset-hold edge count.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    edge_d  = edge_q;

    if (ctl.core_rst_req_i) begin
      // Reset request overrides everything; the clock phase is left alone.
      state_d = ST_HOLD;
      steps_d = '0;
      edge_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (do_rise && (edge_q != EDGE_LAST)) begin
            edge_d = edge_q + EDGE_W'(1);
          end
          // Release the core on a falling edge so it leaves reset with a full
          // low phase ahead of its first active edge.
          if (do_fall && (edge_q == EDGE_LAST)) begin
            state_d = (START_RUNNING != 0) ? ST_RUN : ST_STOP;
          end
        end

        ST_RUN: begin
          if (ctl.stop_i) begin
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          if (ctl.stop_i) begin
            state_d = ST_STOP;
          end else if (ctl.run_i) begin
            state_d = ST_RUN;
          end else if (ctl.step_i && (ctl.step_count_i != '0)) begin
            state_d = ST_STEP;
            steps_d = ctl.step_count_i;
          end
        end

        ST_STEP: begin
          if (ctl.stop_i) begin
            state_d = ST_STOP;
            steps_d = '0;
          end else if (ctl.run_i) begin
            state_d = ST_RUN;
            steps_d = '0;
          end else begin
            if (do_rise && (steps_q != '0)) begin
              steps_d = steps_q - STEP_BITS'(1);
            end
            // Last step edge issued: park once its high phase has finished.
            if (do_fall && (steps_q == '0)) begin
              state_d = ST_STOP;
            end
          end
        end

        default: begin
          state_d = ST_HOLD;
          steps_d = '0;
          edge_d  = '0;
        end
      endcase
    end
  end

  // FSM registers; core reset is registered from the next state to stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      steps_q    <= '0;
      edge_q     <= '0;
      rst_core_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      steps_q    <= steps_d;
      edge_q     <= edge_d;
      rst_core_q <= (state_d == ST_HOLD);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ctl.clk_core_o   = clk_core_q;
  assign ctl.rst_core_o   = rst_core_q;
  assign ctl.core_tick_o  = tick_q;
  assign ctl.running_o    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ctl.steps_left_o = steps_q;
  assign ctl.state_dbg    = state_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Bench for core_clock_ctrl: reset hold, divisor change, stop, step, step
// abort, core reset request and asynchronous reset. Expected tick intervals or
// remaining-step values are queued when a command is driven and consumed as
// core ticks appear.
module tb_core_clock_ctrl;

  localparam int DIV_WIDTH = 16;
  localparam int STEP_BITS = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_clock_ctrl_if #(.DIV_WIDTH(DIV_WIDTH), .STEP_BITS(STEP_BITS)) ctl();

  core_clock_ctrl #(
    .DIV_WIDTH       (DIV_WIDTH),
    .STEP_BITS       (STEP_BITS),
    .RESET_CLK_CYCLES(20),
    .START_RUNNING   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctl(ctl)
  );

  // Scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    ctl.run_i          = 1'b0;
    ctl.stop_i         = 1'b0;
    ctl.step_i         = 1'b0;
    ctl.step_count_i   = '0;
    ctl.core_rst_req_i = 1'b0;
  endtask

  task automatic pulse(input bit run, input bit stop, input bit step,
                       input logic [31:0] cnt, input bit req);
    ctl.run_i          = run;
    ctl.stop_i         = stop;
    ctl.step_i         = step;
    ctl.step_count_i   = cnt;
    ctl.core_rst_req_i = req;
    @(negedge clk);
    idle_inputs();
  endtask

  // Waits for the next core tick; cyc = clk cycles from the call.
  task automatic wait_tick(input string tag, input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (ctl.core_tick_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  // Consume n ticks, comparing interval or steps_left against the queue.
  task automatic consume_ticks(input string tag, input int n, input bit use_steps);
    int          cyc;
    bit          ok;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      wait_tick(tag, 200, cyc, ok);
      if (!ok) return;
      if (exp_q.size() == 0) begin
        check_eq({tag, "_queue_empty"}, 0, 1);
        return;
      end
      e = exp_q.pop_front();
      check_eq(tag, use_steps ? ctl.steps_left_o : 32'(cyc), e);
    end
  endtask

  // No ticks for n cycles and the core clock parked low.
  task automatic quiet(input string tag, input int n);
    int ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (ctl.core_tick_o === 1'b1) ticks++;
    end
    check_eq({tag, "_ticks"}, 32'(ticks), 0);
    check_eq({tag, "_clk_low"}, 32'(ctl.clk_core_o), 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int cyc;
    bit ok;
    int hc;
    int cnt;
    bit dropped;
    bit prev_clk;

    idle_inputs();
    ctl.div_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_clk_core",   32'(ctl.clk_core_o),  0);
    check_eq("rst_rst_core",   32'(ctl.rst_core_o),  1);
    check_eq("rst_tick",       32'(ctl.core_tick_o), 0);
    check_eq("rst_running",    32'(ctl.running_o),   0);
    check_eq("rst_steps_left", ctl.steps_left_o,     0);

    // Reset hold at div 0: first rise on the first edge, then period 2.
    rst = 1'b0;
    exp_q.push_back(1);
    for (int i = 0; i < 19; i++) exp_q.push_back(2);
    consume_ticks("hold_period", 20, 1'b0);
    check_eq("hold_rst_at_tick20", 32'(ctl.rst_core_o), 1);
    dropped  = 1'b0;
    cnt      = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      prev_clk = ctl.clk_core_o;
      @(negedge clk);
      if (ctl.core_tick_o === 1'b1) cnt++;
      if (ctl.rst_core_o === 1'b0) begin
        dropped = 1'b1;
        break;
      end
    end
    check_eq("hold_release",       32'(dropped),        1);
    check_eq("hold_extra_ticks",   32'(cnt),            0);
    check_eq("hold_release_fall",  32'({prev_clk, ctl.clk_core_o}), 32'h2);
    check_eq("hold_running",       32'(ctl.running_o),  1);

    // Divisor 0 -> 3 during a high phase.
    wait_tick("align_div", 10, cyc, ok);
    ctl.div_i = 16'd3;
    exp_q.push_back(5);
    exp_q.push_back(8);
    exp_q.push_back(8);
    consume_ticks("div_change", 3, 1'b0);

    // Stop while high: high phase completes, then parked.
    pulse(1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("stop_running", 32'(ctl.running_o),  0);
    check_eq("stop_still_high", 32'(ctl.clk_core_o), 1);
    hc = 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ctl.clk_core_o === 1'b1) hc++;
      else break;
    end
    check_eq("stop_high_len", 32'(hc), 4);
    quiet("stop_quiet", 40);

    // Step 5 edges from STOP.
    pulse(1'b0, 1'b0, 1'b1, 5, 1'b0);
    check_eq("step5_loaded",  ctl.steps_left_o,    5);
    check_eq("step5_running", 32'(ctl.running_o),  1);
    for (int i = 4; i >= 0; i--) exp_q.push_back(32'(i));
    consume_ticks("step5_left", 5, 1'b1);
    quiet("step5_after", 60);
    check_eq("step5_end_running", 32'(ctl.running_o), 0);
    check_eq("step5_end_left",    ctl.steps_left_o,   0);

    // Step with a zero count is ignored.
    pulse(1'b0, 1'b0, 1'b1, 0, 1'b0);
    check_eq("step0_running", 32'(ctl.running_o), 0);
    quiet("step0_quiet", 40);

    // Step 100, stopped after 3 ticks.
    pulse(1'b0, 1'b0, 1'b1, 100, 1'b0);
    exp_q.push_back(99);
    exp_q.push_back(98);
    exp_q.push_back(97);
    consume_ticks("step100_left", 3, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_eq("step_abort_left",    ctl.steps_left_o,   0);
    check_eq("step_abort_running", 32'(ctl.running_o), 0);
    quiet("step_abort_quiet", 60);

    // stop_i and run_i together during STEP: stop wins.
    pulse(1'b0, 1'b0, 1'b1, 100, 1'b0);
    exp_q.push_back(99);
    consume_ticks("step_prio_left", 1, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check_eq("prio_running", 32'(ctl.running_o), 0);
    check_eq("prio_left",    ctl.steps_left_o,   0);
    quiet("prio_quiet", 40);

    // Core reset request with stop_i in RUN: full hold, then RUN.
    pulse(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("run_running", 32'(ctl.running_o), 1);
    wait_tick("align_req", 40, cyc, ok);
    pulse(1'b0, 1'b1, 1'b0, 0, 1'b1);
    check_eq("req_rst_core", 32'(ctl.rst_core_o), 1);
    check_eq("req_running",  32'(ctl.running_o),  0);
    check_eq("req_left",     ctl.steps_left_o,    0);
    dropped = 1'b0;
    cnt     = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ctl.rst_core_o === 1'b0) begin
        dropped = 1'b1;
        break;
      end
      if (ctl.core_tick_o === 1'b1) cnt++;
    end
    check_eq("req_release",     32'(dropped),        1);
    check_eq("req_hold_ticks",  32'(cnt),            20);
    check_eq("req_release_low", 32'(ctl.clk_core_o), 0);
    check_eq("req_run_after",   32'(ctl.running_o),  1);

    // Asynchronous reset in the middle of a step, while the clock is high.
    pulse(1'b0, 1'b1, 1'b0, 0, 1'b0);
    quiet("pre_arst_quiet", 20);
    pulse(1'b0, 1'b0, 1'b1, 50, 1'b0);
    exp_q.push_back(49);
    exp_q.push_back(48);
    consume_ticks("arst_step_left", 2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_clk_core",   32'(ctl.clk_core_o),  0);
    check_eq("arst_rst_core",   32'(ctl.rst_core_o),  1);
    check_eq("arst_tick",       32'(ctl.core_tick_o), 0);
    check_eq("arst_running",    32'(ctl.running_o),   0);
    check_eq("arst_steps_left", ctl.steps_left_o,     0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("queue_drained", 32'(exp_q.size()), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
